am_multi_ctl: RTL

Parametrised multi-channel successor to the single-axis motor action controller. Each of C_CH channels accepts one motion request over a valid/ready handshake and drives one motor driver's start/stop/modify-remain command port. Modes: open-loop absolute or relative moves, and image-dependent closed-loop moves corrected by the image processor, with bounded iterations. Adds start/stop timeouts, abort, and per-channel error status. Sits between the CPU register file and the motor driver array.

---
 rtl/am_multi_ctl.sv | 334 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/am_multi_ctl.sv
// ---------------------------------------------------------------------------
// am_multi_ctl
//
// Multi-channel motor action controller. Each of C_CH independent channels
// takes one motion request through a valid/ready handshake and sequences the
// start/stop/modify-remain command port of one motor driver. A request is
// either an open-loop move (absolute target or relative step) or an
// image-dependent closed-loop move. In the closed-loop case the image
// processor steers the motor with correction strobes, and the number of
// starts per request is bounded. Each channel has a start and a stop timeout,
// accepts an abort, and reports done/error status.
//
// Ports (channel i occupies bit i, or slice [i*W +: W] of the wide buses):
//   clk, resetn       clock; synchronous active-low reset
//   req_valid/ready   request handshake (ready = channel idle)
//   req_abs           absolute move (open-loop only)
//   req_dep_img       image-dependent closed-loop mode
//   req_speed/step    speed word and signed step/target
//   abort             abort the active request
//   exe_done/err      completion status, held until the next accept
//   m_sel             driver select, follows resetn
//   m_state/m_rt_dir  driver running flag and direction (1 = negative)
//   m_start/stop/mod_remain  one-cycle command pulses
//   m_speed/step/abs  start parameters, held from one start to the next
//   m_new_remain      new remaining steps for m_mod_remain
//   img_pulse/step/ok/should_start  image processor result
// ---------------------------------------------------------------------------
module am_multi_ctl #(
  parameter int C_CH                = 4,
  parameter int C_STEP_NUMBER_WIDTH = 32,
  parameter int C_SPEED_DATA_WIDTH  = 32,
  parameter int C_TIMEOUT_WIDTH     = 24,
  parameter int C_START_TIMEOUT     = 1000000,
  parameter int C_STOP_TIMEOUT      = 1000000,
  parameter int C_MAX_IMG_ITER      = 16
) (
  input  logic                                clk,
  input  logic                                resetn,
  input  logic [C_CH-1:0]                     req_valid,
  output logic [C_CH-1:0]                     req_ready,
  input  logic [C_CH-1:0]                     req_abs,
  input  logic [C_CH-1:0]                     req_dep_img,
  input  logic [C_CH*C_SPEED_DATA_WIDTH-1:0]  req_speed,
  input  logic [C_CH*C_STEP_NUMBER_WIDTH-1:0] req_step,
  input  logic [C_CH-1:0]                     abort,
  output logic [C_CH-1:0]                     exe_done,
  output logic [C_CH-1:0]                     exe_err,
  output logic [C_CH-1:0]                     m_sel,
  input  logic [C_CH-1:0]                     m_state,
  input  logic [C_CH-1:0]                     m_rt_dir,
  output logic [C_CH-1:0]                     m_start,
  output logic [C_CH-1:0]                     m_stop,
  output logic [C_CH-1:0]                     m_mod_remain,
  output logic [C_CH*C_SPEED_DATA_WIDTH-1:0]  m_speed,
  output logic [C_CH*C_STEP_NUMBER_WIDTH-1:0] m_step,
  output logic [C_CH-1:0]                     m_abs,
  output logic [C_CH*C_STEP_NUMBER_WIDTH-1:0] m_new_remain,
  input  logic [C_CH-1:0]                     img_pulse,
  input  logic [C_CH*C_STEP_NUMBER_WIDTH-1:0] img_step,
  input  logic [C_CH-1:0]                     img_ok,
  input  logic [C_CH-1:0]                     img_should_start
);

  localparam int SW = C_STEP_NUMBER_WIDTH;
  localparam int VW = C_SPEED_DATA_WIDTH;
  localparam int TW = C_TIMEOUT_WIDTH;
  localparam int IW = $clog2(C_MAX_IMG_ITER + 1);

  // The timer reads 0 in the cycle the command pulse is on the port, so a
  // match on N-1 makes the registered done land exactly N cycles later.
  localparam logic [TW-1:0] START_LAST = TW'(C_START_TIMEOUT - 1);
  localparam logic [TW-1:0] STOP_LAST  = TW'(C_STOP_TIMEOUT - 1);
  localparam logic [IW-1:0] MAX_ITER   = IW'(C_MAX_IMG_ITER);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LAUNCH, ST_WAIT_RUN, ST_RUN, ST_IMG_WAIT, ST_STOPPING
  } state_e;

  // Why a channel is waiting for the motor to stop.
  typedef enum logic [1:0] {
    WHY_OK, WHY_RESTART, WHY_ABORT
  } why_e;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (&v) ? v : v + TW'(1);
  endfunction

  assign m_sel = {C_CH{resetn}};

  for (genvar i = 0; i < C_CH; i++) begin : g_ch
    logic [VW-1:0]        req_speed_w;
    logic signed [SW-1:0] req_step_w;
    logic signed [SW-1:0] img_step_w;

    assign req_speed_w = req_speed[i*VW +: VW];
    assign req_step_w  = $signed(req_step[i*SW +: SW]);
    assign img_step_w  = $signed(img_step[i*SW +: SW]);

    state_e               state_q, state_d;
    why_e                 why_q, why_d, why_eff;
    logic [TW-1:0]        timer_q, timer_d;
    logic [IW-1:0]        iter_q, iter_d;
    logic                 img_mode_q, img_mode_d;
    logic                 abs_q, abs_d;
    logic [VW-1:0]        speed_q, speed_d;
    logic signed [SW-1:0] step_q, step_d;
    logic                 abort_pend_q, abort_pend_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 start_q, start_d;
    logic                 stop_q, stop_d;
    logic                 mod_q, mod_d;
    logic [VW-1:0]        m_speed_q, m_speed_d;
    logic signed [SW-1:0] m_step_q, m_step_d;
    logic                 m_abs_q, m_abs_d;
    logic signed [SW-1:0] new_rem_q, new_rem_d;
    logic                 abort_req, cmd_busy, fin, fin_err;

    always_comb begin
      state_d      = state_q;
      why_d        = why_q;
      why_eff      = why_q;
      timer_d      = sat_inc(timer_q);
      iter_d       = iter_q;
      img_mode_d   = img_mode_q;
      abs_d        = abs_q;
      speed_d      = speed_q;
      step_d       = step_q;
      abort_pend_d = abort_pend_q;
      done_d       = done_q;
      err_d        = err_q;
      start_d      = 1'b0;
      stop_d       = 1'b0;
      mod_d        = 1'b0;
      m_speed_d    = m_speed_q;
      m_step_d     = m_step_q;
      m_abs_d      = m_abs_q;
      new_rem_d    = new_rem_q;
      fin          = 1'b0;
      fin_err      = 1'b0;
      // An abort arriving while a command pulse is still on the port is
      // remembered, so the stop it triggers never follows a pulse directly.
      abort_req    = abort[i] | abort_pend_q;
      cmd_busy     = start_q | stop_q | mod_q;

      if (state_q == ST_IDLE) begin
        abort_pend_d = 1'b0;
        if (req_valid[i]) begin
          img_mode_d = req_dep_img[i];
          abs_d      = req_abs[i];
          speed_d    = req_speed_w;
          step_d     = req_step_w;
          iter_d     = '0;
          why_d      = WHY_OK;
          done_d     = 1'b0;
          err_d      = 1'b0;
          if (req_dep_img[i]) begin
            state_d = ST_IMG_WAIT;
          end else if (!req_abs[i] && (req_step_w == '0)) begin
            // Zero relative move: nothing to do, report done at once.
            done_d = 1'b1;
          end else begin
            state_d = ST_LAUNCH;
          end
        end
      end else if (state_q == ST_STOPPING) begin
        // The stop is already out; an abort only changes the outcome.
        if (abort_req) why_eff = WHY_ABORT;
        why_d        = why_eff;
        abort_pend_d = 1'b0;
        if (timer_q == STOP_LAST) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end else if (!m_state[i]) begin
          case (why_eff)
            WHY_RESTART: begin
              if (iter_q < MAX_ITER) begin
                state_d = ST_LAUNCH;
              end else begin
                fin     = 1'b1;
                fin_err = 1'b1;
              end
            end
            WHY_OK:  fin = 1'b1;
            default: begin
              fin     = 1'b1;
              fin_err = 1'b1;
            end
          endcase
        end
      end else if (abort_req) begin
        if (m_state[i]) begin
          if (cmd_busy) begin
            abort_pend_d = 1'b1;
          end else begin
            stop_d       = 1'b1;
            why_d        = WHY_ABORT;
            abort_pend_d = 1'b0;
            timer_d      = '0;
            state_d      = ST_STOPPING;
          end
        end else begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end else begin
        case (state_q)
          ST_LAUNCH: begin
            start_d   = 1'b1;
            m_speed_d = speed_q;
            m_step_d  = step_q;
            if (img_mode_q) begin
              m_abs_d = 1'b0;
              iter_d  = iter_q + IW'(1);
            end else begin
              m_abs_d = abs_q;
            end
            timer_d = '0;
            state_d = ST_WAIT_RUN;
          end
          ST_WAIT_RUN: begin
            if (timer_q == START_LAST) begin
              fin     = 1'b1;
              fin_err = 1'b1;
            end else if (m_state[i]) begin
              state_d = ST_RUN;
            end
          end
          ST_RUN: begin
            if (!m_state[i]) begin
              if (img_mode_q) state_d = ST_IMG_WAIT;
              else            fin     = 1'b1;
            end else if (img_mode_q && img_pulse[i] && !cmd_busy) begin
              if (img_ok[i]) begin
                stop_d  = 1'b1;
                why_d   = WHY_OK;
                timer_d = '0;
                state_d = ST_STOPPING;
              end else if (img_step_w[SW-1] == m_rt_dir[i]) begin
                // Correction points the way we are already going: retarget.
                mod_d     = 1'b1;
                new_rem_d = img_step_w;
              end else begin
                // Correction reverses direction: stop, then restart with it.
                stop_d  = 1'b1;
                step_d  = img_step_w;
                why_d   = WHY_RESTART;
                timer_d = '0;
                state_d = ST_STOPPING;
              end
            end
          end
          ST_IMG_WAIT: begin
            if (img_pulse[i]) begin
              if (img_ok[i]) begin
                fin = 1'b1;
              end else if (img_should_start[i] && (img_step_w != '0)) begin
                if (iter_q < MAX_ITER) begin
                  step_d  = img_step_w;
                  state_d = ST_LAUNCH;
                end else begin
                  fin     = 1'b1;
                  fin_err = 1'b1;
                end
              end
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end

      if (fin) begin
        state_d      = ST_IDLE;
        done_d       = 1'b1;
        err_d        = fin_err;
        abort_pend_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!resetn) begin
        state_q      <= ST_IDLE;
        why_q        <= WHY_OK;
        timer_q      <= '0;
        iter_q       <= '0;
        img_mode_q   <= 1'b0;
        abs_q        <= 1'b0;
        speed_q      <= '0;
        step_q       <= '0;
        abort_pend_q <= 1'b0;
        done_q       <= 1'b0;
        err_q        <= 1'b0;
        start_q      <= 1'b0;
        stop_q       <= 1'b0;
        mod_q        <= 1'b0;
        m_speed_q    <= '0;
        m_step_q     <= '0;
        m_abs_q      <= 1'b0;
        new_rem_q    <= '0;
      end else begin
        state_q      <= state_d;
        why_q        <= why_d;
        timer_q      <= timer_d;
        iter_q       <= iter_d;
        img_mode_q   <= img_mode_d;
        abs_q        <= abs_d;
        speed_q      <= speed_d;
        step_q       <= step_d;
        abort_pend_q <= abort_pend_d;
        done_q       <= done_d;
        err_q        <= err_d;
        start_q      <= start_d;
        stop_q       <= stop_d;
        mod_q        <= mod_d;
        m_speed_q    <= m_speed_d;
        m_step_q     <= m_step_d;
        m_abs_q      <= m_abs_d;
        new_rem_q    <= new_rem_d;
      end
    end

    assign req_ready[i]               = (state_q == ST_IDLE);
    assign exe_done[i]                = done_q;
    assign exe_err[i]                 = err_q;
    assign m_start[i]                 = start_q;
    assign m_stop[i]                  = stop_q;
    assign m_mod_remain[i]            = mod_q;
    assign m_speed[i*VW +: VW]        = m_speed_q;
    assign m_step[i*SW +: SW]         = m_step_q;
    assign m_abs[i]                   = m_abs_q;
    assign m_new_remain[i*SW +: SW]   = new_rem_q;
  end

endmodule
